// File: rtl/gnss_acq_pkg.sv
// gnss_acq_pkg: shared constants, FSM states and result-entry type for acquisition peak detection
package gnss_acq_pkg;
  localparam int NUM_CH = 8;
  localparam logic [13:0] CENTER = 14'd8192;
  typedef enum logic {IDLE, SCAN} state_t;
  typedef struct packed {
    logic [5:0] sat;
    logic [14:0] mag;
    logic [9:0] phase;
    logic signed [15:0] doppler;
  } entry_t;
  // magnitude of a 14-bit two's complement value as 14-bit unsigned; -8192 maps to 8192
  function automatic logic [13:0] abs_c(input logic [13:0] c);
    return c[13] ? -c : c;
  endfunction
endpackage

// File: rtl/corr_mag.sv
// corr_mag: combinational correlation magnitude |i-CENTER| + |q-CENTER| for one I/Q pair
//   i, q : 14-bit integrator match counts
//   mag  : 15-bit unsigned magnitude (max 16384)
module corr_mag
  import gnss_acq_pkg::*;
#(
  parameter logic [13:0] CENTER = gnss_acq_pkg::CENTER
) (
  input  logic [13:0] i,
  input  logic [13:0] q,
  output logic [14:0] mag
);
  logic [13:0] ci, cq;
  always_comb begin
    ci = i - CENTER;
    cq = q - CENTER;
    mag = {1'b0, abs_c(ci)} + {1'b0, abs_c(cq)};
  end
endmodule

// File: rtl/acq_peak_detect.sv
// acq_peak_detect: snapshots 8-channel correlator output and tracks per-channel peak magnitude
//   clk, rst (async, active-low)
//   ack_start            : clears result table, flags, aborts scan
//   corr_complete        : level flag; rising edge triggers a snapshot
//   search_complete      : rising edge arms results_valid
//   code_phase, doppler_omega, sat0..7, integrator_i0..7/q0..7 : snapshot data
//   rd_sel -> rd_sat/rd_mag/rd_phase/rd_doppler/rd_detected : combinational table read
//   busy, results_valid, overrun : status
module acq_peak_detect
  import gnss_acq_pkg::*;
#(
  parameter logic [14:0] THRESH = 15'd600,
  parameter logic [13:0] CENTER = gnss_acq_pkg::CENTER
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ack_start,
  input  logic               corr_complete,
  input  logic               search_complete,
  input  logic [9:0]         code_phase,
  input  logic signed [15:0] doppler_omega,
  input  logic [5:0]         sat0,
  input  logic [5:0]         sat1,
  input  logic [5:0]         sat2,
  input  logic [5:0]         sat3,
  input  logic [5:0]         sat4,
  input  logic [5:0]         sat5,
  input  logic [5:0]         sat6,
  input  logic [5:0]         sat7,
  input  logic [13:0]        integrator_i0,
  input  logic [13:0]        integrator_i1,
  input  logic [13:0]        integrator_i2,
  input  logic [13:0]        integrator_i3,
  input  logic [13:0]        integrator_i4,
  input  logic [13:0]        integrator_i5,
  input  logic [13:0]        integrator_i6,
  input  logic [13:0]        integrator_i7,
  input  logic [13:0]        integrator_q0,
  input  logic [13:0]        integrator_q1,
  input  logic [13:0]        integrator_q2,
  input  logic [13:0]        integrator_q3,
  input  logic [13:0]        integrator_q4,
  input  logic [13:0]        integrator_q5,
  input  logic [13:0]        integrator_q6,
  input  logic [13:0]        integrator_q7,
  input  logic [2:0]         rd_sel,
  output logic [5:0]         rd_sat,
  output logic [14:0]        rd_mag,
  output logic [9:0]         rd_phase,
  output logic signed [15:0] rd_doppler,
  output logic               rd_detected,
  output logic               busy,
  output logic               results_valid,
  output logic               overrun
);
  logic [13:0] in_i [NUM_CH];
  logic [13:0] in_q [NUM_CH];
  logic [5:0] in_sat [NUM_CH];
  logic [13:0] snap_i [NUM_CH];
  logic [13:0] snap_q [NUM_CH];
  logic [5:0] snap_sat [NUM_CH];
  logic [9:0] snap_phase;
  logic signed [15:0] snap_dop;
  entry_t tbl [NUM_CH];
  state_t state, state_nx;
  logic [2:0] idx;
  logic corr_q, search_q, pending, rv, ovr;
  logic rise, accept, drop, scan;
  logic [14:0] mag;
  entry_t sel;

  assign in_i = '{integrator_i0, integrator_i1, integrator_i2, integrator_i3,
                  integrator_i4, integrator_i5, integrator_i6, integrator_i7};
  assign in_q = '{integrator_q0, integrator_q1, integrator_q2, integrator_q3,
                  integrator_q4, integrator_q5, integrator_q6, integrator_q7};
  assign in_sat = '{sat0, sat1, sat2, sat3, sat4, sat5, sat6, sat7};

  // ack_start outranks a coincident rise: it neither starts a scan nor counts as overrun
  assign rise = corr_complete & ~corr_q;
  assign accept = rise & ~busy & ~ack_start;
  assign drop = rise & busy & ~ack_start;

  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nx;

  always_comb begin
    state_nx = ack_start ? IDLE :
               state == IDLE ? (accept ? SCAN : IDLE) :
               idx == 3'd7 ? IDLE : SCAN;
  end

  always_comb begin
    busy = state == SCAN;
    scan = busy & ~ack_start;
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) idx <= '0;
    else idx <= scan ? idx + 3'd1 : 3'd0;

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      for (int k = 0; k < NUM_CH; k++) begin
        snap_i[k] <= '0;
        snap_q[k] <= '0;
        snap_sat[k] <= '0;
      end
      snap_phase <= '0;
      snap_dop <= '0;
    end else if (accept) begin
      snap_i <= in_i;
      snap_q <= in_q;
      snap_sat <= in_sat;
      snap_phase <= code_phase;
      snap_dop <= doppler_omega;
    end

  corr_mag #(.CENTER(CENTER)) u_mag (
    .i   (snap_i[idx]),
    .q   (snap_q[idx]),
    .mag (mag)
  );

  // strict compare so an equal later peak keeps the earlier phase/doppler
  always_ff @(posedge clk or negedge rst)
    if (!rst) for (int k = 0; k < NUM_CH; k++) tbl[k] <= '0;
    else if (ack_start) for (int k = 0; k < NUM_CH; k++) tbl[k] <= '0;
    else if (scan) begin
      tbl[idx].sat <= snap_sat[idx];
      if (mag > tbl[idx].mag) begin
        tbl[idx].mag <= mag;
        tbl[idx].phase <= snap_phase;
        tbl[idx].doppler <= snap_dop;
      end
    end

  // results become valid only once no scan is running and none is about to start
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      corr_q <= 1'b0;
      search_q <= 1'b0;
      pending <= 1'b0;
      rv <= 1'b0;
      ovr <= 1'b0;
    end else begin
      corr_q <= corr_complete;
      search_q <= search_complete;
      pending <= ~ack_start & (pending | (search_complete & ~search_q));
      rv <= ~ack_start & (rv | (pending & ~busy & ~accept));
      ovr <= ~ack_start & (ovr | drop);
    end

  assign sel = tbl[rd_sel];
  assign rd_sat = sel.sat;
  assign rd_mag = sel.mag;
  assign rd_phase = sel.phase;
  assign rd_doppler = sel.doppler;
  assign rd_detected = sel.mag >= THRESH;
  assign results_valid = rv;
  assign overrun = ovr;
endmodule

// File: tb/tb_acq_peak_detect.sv
// tb_acq_peak_detect: directed stimulus, reference table model and per-cycle compare for acq_peak_detect
module tb_acq_peak_detect;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic ack = 1'b0;
  logic corr = 1'b0;
  logic srch = 1'b0;
  logic [9:0] phase = '0;
  logic signed [15:0] omega = '0;
  logic [5:0] ss [8];
  logic [13:0] ii [8];
  logic [13:0] qq [8];
  logic [2:0] rd_sel = '0;
  logic [5:0] rd_sat;
  logic [14:0] rd_mag;
  logic [9:0] rd_phase;
  logic signed [15:0] rd_doppler;
  logic rd_detected, busy, results_valid, overrun;

  int n_chk = 0;
  int n_fail = 0;

  int m_mag [8], m_phase [8], m_dop [8], m_sat [8];
  int s_i [8], s_q [8], s_sat [8];
  int s_ph, s_dop;
  int cnt = 0;
  bit m_cq = 0;
  bit m_ovr = 0;

  always #5 clk = ~clk;

  acq_peak_detect dut (
    .clk(clk), .rst(rst), .ack_start(ack), .corr_complete(corr), .search_complete(srch),
    .code_phase(phase), .doppler_omega(omega),
    .sat0(ss[0]), .sat1(ss[1]), .sat2(ss[2]), .sat3(ss[3]),
    .sat4(ss[4]), .sat5(ss[5]), .sat6(ss[6]), .sat7(ss[7]),
    .integrator_i0(ii[0]), .integrator_i1(ii[1]), .integrator_i2(ii[2]), .integrator_i3(ii[3]),
    .integrator_i4(ii[4]), .integrator_i5(ii[5]), .integrator_i6(ii[6]), .integrator_i7(ii[7]),
    .integrator_q0(qq[0]), .integrator_q1(qq[1]), .integrator_q2(qq[2]), .integrator_q3(qq[3]),
    .integrator_q4(qq[4]), .integrator_q5(qq[5]), .integrator_q6(qq[6]), .integrator_q7(qq[7]),
    .rd_sel(rd_sel), .rd_sat(rd_sat), .rd_mag(rd_mag), .rd_phase(rd_phase),
    .rd_doppler(rd_doppler), .rd_detected(rd_detected), .busy(busy),
    .results_valid(results_valid), .overrun(overrun)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int cmag(input int i, input int q);
    int ci, cq;
    ci = i - 8192;
    cq = q - 8192;
    return (ci < 0 ? -ci : ci) + (cq < 0 ? -cq : cq);
  endfunction

  task automatic clear_model();
    for (int k = 0; k < 8; k++) begin
      m_mag[k] = 0;
      m_phase[k] = 0;
      m_dop[k] = 0;
      m_sat[k] = 0;
    end
  endtask

  // reference: a snapshot is folded into the table as a whole once its 8-cycle busy window ends
  always @(posedge clk) begin
    bit rs, bz;
    int mg;
    if (!rst) begin
      clear_model();
      cnt = 0;
      m_cq = 0;
      m_ovr = 0;
    end else begin
      rs = corr && !m_cq;
      m_cq = corr;
      bz = cnt > 0;
      if (ack) begin
        clear_model();
        cnt = 0;
        m_ovr = 0;
      end else begin
        if (bz) begin
          cnt--;
          if (cnt == 0)
            for (int k = 0; k < 8; k++) begin
              m_sat[k] = s_sat[k];
              mg = cmag(s_i[k], s_q[k]);
              if (mg > m_mag[k]) begin
                m_mag[k] = mg;
                m_phase[k] = s_ph;
                m_dop[k] = s_dop;
              end
            end
        end
        if (rs) begin
          if (bz) m_ovr = 1;
          else begin
            cnt = 8;
            for (int k = 0; k < 8; k++) begin
              s_i[k] = int'(ii[k]);
              s_q[k] = int'(qq[k]);
              s_sat[k] = int'(ss[k]);
            end
            s_ph = int'(phase);
            s_dop = int'(omega);
          end
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    chk("busy", busy, cnt > 0);
    chk("overrun", overrun, m_ovr);
    if (cnt == 0) begin
      chk("rd_mag", rd_mag, m_mag[rd_sel]);
      chk("rd_phase", rd_phase, m_phase[rd_sel]);
      chk("rd_doppler", rd_doppler, m_dop[rd_sel]);
      chk("rd_sat", rd_sat, m_sat[rd_sel]);
      chk("rd_detected", rd_detected, m_mag[rd_sel] >= 600);
    end
  end

  task automatic base();
    for (int k = 0; k < 8; k++) begin
      ii[k] = 14'd8192;
      qq[k] = 14'd8192;
      ss[k] = 6'(k + 1);
    end
  endtask

  task automatic fire(input bit acc, input bit s);
    corr = 1'b1;
    @(negedge clk);
    chk("busy_t1", busy, acc);
    if (s) srch = 1'b1;
    @(negedge clk);
    corr = 1'b0;
    repeat (6) @(negedge clk);
    chk("busy_t8", busy, acc);
    if (s) chk("rv_during_scan", results_valid, 0);
    @(negedge clk);
    chk("busy_t9", busy, 0);
  endtask

  task automatic do_ack();
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    @(negedge clk);
  endtask

  task automatic look(input int k);
    rd_sel = 3'(k);
    #1;
  endtask

  initial begin
    base();
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    look(3);
    chk("rst_mag", rd_mag, 0);
    chk("rst_det", rd_detected, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rv", results_valid, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    base();
    ii[0] = 14'd9000;
    phase = 10'd17;
    omega = 16'sd13;
    fire(1, 0);
    look(0);
    chk("one_mag", rd_mag, 808);
    chk("one_phase", rd_phase, 17);
    chk("one_dop", rd_doppler, 13);
    chk("one_det", rd_detected, 1);
    chk("one_sat", rd_sat, 1);

    base();
    ii[3] = 14'd0;
    phase = 10'd20;
    omega = -16'sd300;
    fire(1, 0);
    look(3);
    chk("wrap_mag", rd_mag, 8192);
    chk("wrap_dop", rd_doppler, -300);

    do_ack();
    base();
    ii[2] = 14'd8692;
    phase = 10'd4;
    fire(1, 0);
    phase = 10'd5;
    fire(1, 0);
    look(2);
    chk("tie_phase", rd_phase, 4);
    chk("tie_mag", rd_mag, 500);
    chk("tie_det", rd_detected, 0);
    ii[2] = 14'd8192;
    qq[2] = 14'd7691;
    phase = 10'd9;
    fire(1, 0);
    chk("gt_phase", rd_phase, 9);
    chk("gt_mag", rd_mag, 501);
    qq[2] = 14'd7593;
    phase = 10'd10;
    fire(1, 0);
    chk("thr599_det", rd_detected, 0);
    qq[2] = 14'd7592;
    phase = 10'd11;
    fire(1, 0);
    chk("thr600_det", rd_detected, 1);
    chk("thr600_phase", rd_phase, 11);

    do_ack();
    base();
    ii[1] = 14'd9100;
    phase = 10'd30;
    corr = 1'b1;
    repeat (2) @(negedge clk);
    corr = 1'b0;
    ii[1] = 14'd12000;
    phase = 10'd31;
    repeat (2) @(negedge clk);
    corr = 1'b1;
    repeat (2) @(negedge clk);
    corr = 1'b0;
    repeat (6) @(negedge clk);
    look(1);
    chk("ovr_flag", overrun, 1);
    chk("ovr_mag", rd_mag, 908);
    chk("ovr_phase", rd_phase, 30);
    do_ack();
    chk("ovr_clear", overrun, 0);

    base();
    ii[4] = 14'd8800;
    phase = 10'd40;
    fire(1, 1);
    for (int n = 0; n < 6 && !results_valid; n++) @(negedge clk);
    chk("rv_set", results_valid, 1);
    srch = 1'b0;
    repeat (3) @(negedge clk);
    chk("rv_hold", results_valid, 1);

    ii[0] = 14'd9500;
    corr = 1'b1;
    repeat (2) @(negedge clk);
    corr = 1'b0;
    @(negedge clk);
    ack = 1'b1;
    corr = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    corr = 1'b0;
    chk("ackc_busy", busy, 0);
    chk("ackc_ovr", overrun, 0);
    chk("ackc_rv", results_valid, 0);
    for (int k = 0; k < 8; k++) begin
      look(k);
      chk("ackc_mag", rd_mag, 0);
      chk("ackc_sat", rd_sat, 0);
    end
    @(negedge clk);
    chk("ackc_idle", busy, 0);

    base();
    ii[5] = 14'd10000;
    corr = 1'b1;
    repeat (2) @(negedge clk);
    corr = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    look(5);
    chk("rstscan_mag", rd_mag, 0);
    chk("rstscan_sat", rd_sat, 0);
    chk("rstscan_busy", busy, 0);
    look(0);
    chk("rstscan_sat0", rd_sat, 0);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
